// File: rtl/wb_arbiter_2m.sv
// Two-master Wishbone B4 arbiter: round-robin grant held for a whole cycle,
// with a bus watchdog that terminates a hung transfer with err.
module wb_arbiter_2m #(
    parameter int AW      = 32,
    parameter int DW      = 32,
    parameter int TIMEOUT = 255
) (
    input  logic            wb_clk_i,
    input  logic            wb_rst_i,
    input  logic [AW-1:0]   m0_adr_i,
    input  logic [DW-1:0]   m0_dat_i,
    input  logic [DW/8-1:0] m0_sel_i,
    input  logic            m0_we_i,
    input  logic            m0_cyc_i,
    input  logic            m0_stb_i,
    input  logic [2:0]      m0_cti_i,
    input  logic [1:0]      m0_bte_i,
    output logic [DW-1:0]   m0_dat_o,
    output logic            m0_ack_o,
    output logic            m0_err_o,
    output logic            m0_rty_o,
    input  logic [AW-1:0]   m1_adr_i,
    input  logic [DW-1:0]   m1_dat_i,
    input  logic [DW/8-1:0] m1_sel_i,
    input  logic            m1_we_i,
    input  logic            m1_cyc_i,
    input  logic            m1_stb_i,
    input  logic [2:0]      m1_cti_i,
    input  logic [1:0]      m1_bte_i,
    output logic [DW-1:0]   m1_dat_o,
    output logic            m1_ack_o,
    output logic            m1_err_o,
    output logic            m1_rty_o,
    output logic [AW-1:0]   s_adr_o,
    output logic [DW-1:0]   s_dat_o,
    output logic [DW/8-1:0] s_sel_o,
    output logic            s_we_o,
    output logic            s_cyc_o,
    output logic            s_stb_o,
    output logic [2:0]      s_cti_o,
    output logic [1:0]      s_bte_o,
    input  logic [DW-1:0]   s_dat_i,
    input  logic            s_ack_i,
    input  logic            s_err_i,
    input  logic            s_rty_i,
    output logic [1:0]      gnt_o
);

    localparam int WW = $clog2(TIMEOUT + 1);
    localparam logic [WW-1:0] TO_VAL = WW'(TIMEOUT);

    typedef enum logic [2:0] {S_IDLE, S_GNT0, S_GNT1, S_TOERR, S_DRAIN} state_t;

    state_t        r_state;
    logic          r_last;
    logic [1:0]    r_gnt;
    logic [WW-1:0] r_wdt;

    logic w_gnt0, w_gnt1, w_cur_cyc, w_cur_stb, w_resp, w_toerr;

    assign w_gnt0    = (r_state == S_GNT0);
    assign w_gnt1    = (r_state == S_GNT1);
    assign w_toerr   = (r_state == S_TOERR);
    // r_last names the master that owns GNTx/TOERR/DRAIN
    assign w_cur_cyc = r_last ? m1_cyc_i : m0_cyc_i;
    assign w_cur_stb = r_last ? m1_stb_i : m0_stb_i;
    assign w_resp    = s_ack_i | s_err_i | s_rty_i;

    always_ff @(posedge wb_clk_i or posedge wb_rst_i) begin
        if (wb_rst_i) begin
            r_state <= S_IDLE;
            r_last  <= 1'b1;
            r_gnt   <= 2'b00;
            r_wdt   <= '0;
        end else begin
            case (r_state)
                S_IDLE: begin
                    r_wdt <= '0;
                    if (m0_cyc_i && (!m1_cyc_i || r_last)) begin
                        r_state <= S_GNT0;
                        r_last  <= 1'b0;
                        r_gnt   <= 2'b01;
                    end else if (m1_cyc_i) begin
                        r_state <= S_GNT1;
                        r_last  <= 1'b1;
                        r_gnt   <= 2'b10;
                    end
                end
                S_GNT0, S_GNT1: begin
                    if (!w_cur_cyc) begin
                        r_state <= S_IDLE;
                        r_gnt   <= 2'b00;
                        r_wdt   <= '0;
                    end else if (w_resp) begin
                        r_wdt <= '0;
                    end else if (r_wdt == TO_VAL) begin
                        r_state <= S_TOERR;
                        r_gnt   <= 2'b00;
                        r_wdt   <= '0;
                    end else if (w_cur_stb) begin
                        r_wdt <= r_wdt + WW'(1);
                    end
                end
                S_TOERR: begin
                    r_state <= S_DRAIN;
                    r_wdt   <= '0;
                end
                S_DRAIN: begin
                    if (!w_cur_cyc) begin
                        r_state <= S_IDLE;
                    end
                end
                default: begin
                    r_state <= S_IDLE;
                    r_gnt   <= 2'b00;
                    r_wdt   <= '0;
                end
            endcase
        end
    end

    // Slave port mirrors the granted master; idle outputs are all zero
    always_comb begin
        s_adr_o = '0;
        s_dat_o = '0;
        s_sel_o = '0;
        s_we_o  = 1'b0;
        s_cyc_o = 1'b0;
        s_stb_o = 1'b0;
        s_cti_o = 3'b000;
        s_bte_o = 2'b00;
        if (w_gnt0) begin
            s_adr_o = m0_adr_i;
            s_dat_o = m0_dat_i;
            s_sel_o = m0_sel_i;
            s_we_o  = m0_we_i;
            s_cyc_o = m0_cyc_i;
            s_stb_o = m0_stb_i;
            s_cti_o = m0_cti_i;
            s_bte_o = m0_bte_i;
        end else if (w_gnt1) begin
            s_adr_o = m1_adr_i;
            s_dat_o = m1_dat_i;
            s_sel_o = m1_sel_i;
            s_we_o  = m1_we_i;
            s_cyc_o = m1_cyc_i;
            s_stb_o = m1_stb_i;
            s_cti_o = m1_cti_i;
            s_bte_o = m1_bte_i;
        end
    end

    // Read data is gated during reset so every output is 0 while it is held
    assign m0_dat_o = wb_rst_i ? '0 : s_dat_i;
    assign m1_dat_o = wb_rst_i ? '0 : s_dat_i;

    assign m0_ack_o = w_gnt0 & s_ack_i;
    assign m0_rty_o = w_gnt0 & s_rty_i;
    assign m0_err_o = (w_gnt0 & s_err_i) | (w_toerr & ~r_last);
    assign m1_ack_o = w_gnt1 & s_ack_i;
    assign m1_rty_o = w_gnt1 & s_rty_i;
    assign m1_err_o = (w_gnt1 & s_err_i) | (w_toerr & r_last);

    assign gnt_o = r_gnt;

endmodule

// File: tb/tb_wb_arbiter_2m.sv
// Bench for wb_arbiter_2m: directed arbitration/burst/watchdog/reset cases
// plus a randomized soak against a transaction-level round-robin model.
module tb_wb_arbiter_2m;

    localparam int AW = 32;
    localparam int DW = 32;
    localparam int TO = 8;
    localparam int N  = 1000;

    logic          clk = 1'b0;
    logic          rst = 1'b1;
    logic [AW-1:0] m0_adr_i, m1_adr_i, s_adr_o;
    logic [DW-1:0] m0_dat_i, m1_dat_i, m0_dat_o, m1_dat_o, s_dat_o, s_dat_i;
    logic [3:0]    m0_sel_i, m1_sel_i, s_sel_o;
    logic          m0_we_i, m0_cyc_i, m0_stb_i, m1_we_i, m1_cyc_i, m1_stb_i;
    logic [2:0]    m0_cti_i, m1_cti_i, s_cti_o;
    logic [1:0]    m0_bte_i, m1_bte_i, s_bte_o, gnt_o;
    logic          m0_ack_o, m0_err_o, m0_rty_o, m1_ack_o, m1_err_o, m1_rty_o;
    logic          s_we_o, s_cyc_o, s_stb_o, s_ack_i, s_err_i, s_rty_i;

    int n_vec = 0;
    int n_err = 0;

    wb_arbiter_2m #(.AW(AW), .DW(DW), .TIMEOUT(TO)) dut (
        .wb_clk_i(clk), .wb_rst_i(rst),
        .m0_adr_i(m0_adr_i), .m0_dat_i(m0_dat_i), .m0_sel_i(m0_sel_i), .m0_we_i(m0_we_i),
        .m0_cyc_i(m0_cyc_i), .m0_stb_i(m0_stb_i), .m0_cti_i(m0_cti_i), .m0_bte_i(m0_bte_i),
        .m0_dat_o(m0_dat_o), .m0_ack_o(m0_ack_o), .m0_err_o(m0_err_o), .m0_rty_o(m0_rty_o),
        .m1_adr_i(m1_adr_i), .m1_dat_i(m1_dat_i), .m1_sel_i(m1_sel_i), .m1_we_i(m1_we_i),
        .m1_cyc_i(m1_cyc_i), .m1_stb_i(m1_stb_i), .m1_cti_i(m1_cti_i), .m1_bte_i(m1_bte_i),
        .m1_dat_o(m1_dat_o), .m1_ack_o(m1_ack_o), .m1_err_o(m1_err_o), .m1_rty_o(m1_rty_o),
        .s_adr_o(s_adr_o), .s_dat_o(s_dat_o), .s_sel_o(s_sel_o), .s_we_o(s_we_o),
        .s_cyc_o(s_cyc_o), .s_stb_o(s_stb_o), .s_cti_o(s_cti_o), .s_bte_o(s_bte_o),
        .s_dat_i(s_dat_i), .s_ack_i(s_ack_i), .s_err_i(s_err_i), .s_rty_i(s_rty_i),
        .gnt_o(gnt_o)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_vec++;
        if (obs !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h exp %0h", tag, obs, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic samp();
        @(negedge clk);
    endtask

    task automatic set_m(input int i, input logic cyc, input logic stb,
                         input logic [31:0] adr, input logic [2:0] cti);
        if (i == 0) begin
            m0_cyc_i = cyc; m0_stb_i = stb; m0_adr_i = adr; m0_cti_i = cti;
            m0_dat_i = $urandom; m0_we_i = 1'($urandom_range(0, 1)); m0_sel_i = 4'hF; m0_bte_i = 2'b00;
        end else begin
            m1_cyc_i = cyc; m1_stb_i = stb; m1_adr_i = adr; m1_cti_i = cti;
            m1_dat_i = $urandom; m1_we_i = 1'($urandom_range(0, 1)); m1_sel_i = 4'hF; m1_bte_i = 2'b00;
        end
    endtask

    // soak model state
    int          ncomp[2];
    int          gc[2];
    bit          act[2];
    bit          done[2];
    bit          busy, own_v, mlast;
    int          wt, own, e, cyc_n, diff;
    logic [1:0]  prev_req, prev_gnt, exp_ack;

    initial begin
        set_m(0, 1'b1, 1'b1, 32'h1234, 3'd0);
        set_m(1, 1'b0, 1'b0, 32'h0, 3'd0);
        s_ack_i = 1'b0; s_err_i = 1'b0; s_rty_i = 1'b0; s_dat_i = 32'hDEADBEEF;
        samp(); samp();
        chk("rst gnt", 64'(gnt_o), 0);
        chk("rst s_cyc", 64'(s_cyc_o), 0);
        chk("rst s_stb", 64'(s_stb_o), 0);
        chk("rst s_adr", 64'(s_adr_o), 0);
        chk("rst m0_dat", 64'(m0_dat_o), 0);
        chk("rst m0_ack", 64'(m0_ack_o), 0);
        set_m(0, 1'b0, 1'b0, 32'h0, 3'd0);
        step(); rst = 1'b0; s_dat_i = '0;

        // single requester, slave answers after 2 cycles
        step(); set_m(0, 1'b1, 1'b1, 32'h1000, 3'd0); m0_we_i = 1'b0;
        samp(); chk("t1 lat", 64'(s_cyc_o), 0);
        step(); samp();
        chk("t1 s_cyc", 64'(s_cyc_o), 1);
        chk("t1 adr", 64'(s_adr_o), 64'h1000);
        chk("t1 gnt", 64'(gnt_o), 64'b01);
        step(); samp(); chk("t1 wait", 64'(m0_ack_o), 0);
        step(); s_ack_i = 1'b1; s_dat_i = 32'hCAFE0001;
        samp();
        chk("t1 ack", 64'(m0_ack_o), 1);
        chk("t1 dat", 64'(m0_dat_o), 64'hCAFE0001);
        chk("t1 m1 ack", 64'(m1_ack_o), 0);
        step(); s_ack_i = 1'b0; set_m(0, 1'b0, 1'b0, 32'h0, 3'd0);
        samp(); chk("t1 drop", 64'(s_cyc_o), 0);
        step(); samp(); chk("t1 idle", 64'(gnt_o), 0);

        // simultaneous request straight out of reset
        step(); rst = 1'b1;
        step(); rst = 1'b0;
        set_m(0, 1'b1, 1'b1, 32'hA0, 3'd0);
        set_m(1, 1'b1, 1'b1, 32'hB0, 3'd0);
        samp();
        step(); samp();
        chk("t2 first", 64'(gnt_o), 64'b01);
        chk("t2 adr0", 64'(s_adr_o), 64'hA0);
        step(); s_ack_i = 1'b1;
        samp(); chk("t2 ack0", 64'({m1_ack_o, m0_ack_o}), 64'b01);
        step(); s_ack_i = 1'b0; set_m(0, 1'b0, 1'b0, 32'h0, 3'd0);
        samp();
        step(); samp(); chk("t2 gap", 64'(gnt_o), 0);
        step(); samp();
        chk("t2 second", 64'(gnt_o), 64'b10);
        chk("t2 adr1", 64'(s_adr_o), 64'hB0);
        step(); s_ack_i = 1'b1;
        samp(); chk("t2 ack1", 64'({m1_ack_o, m0_ack_o}), 64'b10);
        step(); s_ack_i = 1'b0; set_m(1, 1'b0, 1'b0, 32'h0, 3'd0);
        step(); samp(); chk("t2 idle", 64'(gnt_o), 0);

        // m1 4-beat incrementing burst while m0 requests
        step(); set_m(1, 1'b1, 1'b1, 32'h2000, 3'b010);
        samp();
        for (int b = 0; b < 4; b++) begin
            step();
            if (b == 0) set_m(0, 1'b1, 1'b1, 32'h3000, 3'd0);
            m1_adr_i = 32'h2000 + 32'(4 * b);
            m1_cti_i = (b == 3) ? 3'b111 : 3'b010;
            s_ack_i = 1'b1;
            samp();
            chk("t3 ack", 64'({m1_ack_o, m0_ack_o}), 64'b10);
            chk("t3 cti", 64'(s_cti_o), (b == 3) ? 64'd7 : 64'd2);
            chk("t3 gnt", 64'(gnt_o), 64'b10);
        end
        step(); s_ack_i = 1'b0; set_m(1, 1'b0, 1'b0, 32'h0, 3'd0);
        samp(); chk("t3 hold", 64'(gnt_o), 64'b10);
        step(); samp(); chk("t3 idle", 64'(gnt_o), 0);

        // watchdog: m0 strobing, slave silent
        for (int k = 0; k < 12; k++) begin
            step(); samp();
            if (k == 0) chk("t4 gnt0", 64'(gnt_o), 64'b01);
            chk("t4 err", 64'(m0_err_o), (k == 9) ? 64'd1 : 64'd0);
            chk("t4 s_cyc", 64'(s_cyc_o), (k < 9) ? 64'd1 : 64'd0);
            chk("t4 m1 err", 64'(m1_err_o), 0);
        end
        step(); set_m(1, 1'b1, 1'b1, 32'h4000, 3'd0);
        samp(); chk("t4 drain", 64'(gnt_o), 0);
        step(); samp(); chk("t4 drain2", 64'(gnt_o), 0);
        step(); set_m(0, 1'b0, 1'b0, 32'h0, 3'd0);
        samp(); chk("t4 drain cyc", 64'(s_cyc_o), 0);
        step(); samp(); chk("t4 idle", 64'(gnt_o), 0);
        step(); samp(); chk("t4 release", 64'(gnt_o), 64'b10);
        step(); s_ack_i = 1'b1;
        step(); s_ack_i = 1'b0; set_m(1, 1'b0, 1'b0, 32'h0, 3'd0);
        step(); step();

        // asynchronous reset during beat 2 of an m0 burst
        step(); set_m(0, 1'b1, 1'b1, 32'h5000, 3'b010);
        step(); samp(); chk("t5 gnt", 64'(gnt_o), 64'b01);
        step(); s_ack_i = 1'b1;
        step(); m0_adr_i = 32'h5004; s_dat_i = 32'h55AA55AA;
        #2; rst = 1'b1; #1;
        chk("t5 rst gnt", 64'(gnt_o), 0);
        chk("t5 rst s_cyc", 64'(s_cyc_o), 0);
        chk("t5 rst s_stb", 64'(s_stb_o), 0);
        chk("t5 rst s_adr", 64'(s_adr_o), 0);
        chk("t5 rst m0_ack", 64'(m0_ack_o), 0);
        chk("t5 rst m0_dat", 64'(m0_dat_o), 0);
        s_ack_i = 1'b0;
        set_m(1, 1'b1, 1'b1, 32'h6000, 3'd0);
        step(); rst = 1'b0;
        samp(); chk("t5 idle", 64'(gnt_o), 0);
        step(); samp(); chk("t5 tie", 64'(gnt_o), 64'b01);
        step(); set_m(0, 1'b0, 1'b0, 32'h0, 3'd0); set_m(1, 1'b0, 1'b0, 32'h0, 3'd0);
        step(); rst = 1'b1;
        step(); rst = 1'b0;

        // fairness soak: both masters back-to-back random single cycles
        ncomp = '{0, 0}; gc = '{0, 0}; act = '{0, 0}; done = '{0, 0};
        busy = 0; own_v = 0; mlast = 1; wt = 0; own = 0; cyc_n = 0;
        prev_req = 2'b00; prev_gnt = 2'b00;
        while ((ncomp[0] < N || ncomp[1] < N) && cyc_n < 40000) begin
            step();
            s_ack_i = 1'b0;
            if (busy) begin
                if (wt == 0) begin
                    s_ack_i = 1'b1; s_dat_i = $urandom; busy = 0;
                end else wt--;
            end
            for (int i = 0; i < 2; i++) begin
                if (done[i]) begin
                    set_m(i, 1'b0, 1'b0, 32'h0, 3'd0); act[i] = 0; done[i] = 0;
                end else if (!act[i] && ncomp[i] < N) begin
                    set_m(i, 1'b1, 1'b1, $urandom, 3'd0); act[i] = 1;
                end
            end
            samp();
            if (gnt_o != 2'b00 && prev_gnt == 2'b00) begin
                e = (prev_req == 2'b11) ? (mlast ? 0 : 1) : (prev_req[0] ? 0 : 1);
                chk("rr gnt", 64'(gnt_o), 64'(1) << e);
                chk("rr adr", 64'(s_adr_o), (e == 1) ? 64'(m1_adr_i) : 64'(m0_adr_i));
                mlast = (e == 1); own = e; own_v = 1; gc[e]++;
                diff = (gc[0] > gc[1]) ? gc[0] - gc[1] : gc[1] - gc[0];
                chk("rr fair", 64'(diff <= 1), 1);
            end
            exp_ack = (s_ack_i && own_v) ? (2'b01 << own) : 2'b00;
            chk("ack route", 64'({m1_ack_o, m0_ack_o}), 64'(exp_ack));
            if (s_ack_i) own_v = 0;
            if (m0_ack_o) begin done[0] = 1; ncomp[0]++; end
            if (m1_ack_o) begin done[1] = 1; ncomp[1]++; end
            if (s_cyc_o && s_stb_o && !busy && !s_ack_i) begin
                busy = 1; wt = $urandom_range(0, 3);
            end
            prev_gnt = gnt_o;
            prev_req = {m1_cyc_i, m0_cyc_i};
            cyc_n++;
        end
        chk("soak done", 64'(ncomp[0] + ncomp[1]), 64'(2 * N));
        chk("soak g0", 64'(gc[0]), 64'(N));
        chk("soak g1", 64'(gc[1]), 64'(N));

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
